ofdm_cp_inserter: RTL and testbench
===================================

Name: ofdm_cp_inserter

Overview:
Transmit-side counterpart of the ML timing/CFO estimator. The block accepts complex time-domain OFDM symbols of N_FFT samples in r_t format. For each symbol it emits a cyclic prefix (the last N_CP samples) followed by the full symbol. The output is the r stream that the estimator consumes.
It sits between the IFFT/stimulus source and the receiver chain, and is also used as the bench-side symbol source for the estimator.

Parameters:
N_FFT, 256, samples per OFDM symbol body (power of two; write/read index width = log2(N_FFT))
N_CP, 16, cyclic-prefix length; 1 <= N_CP < N_FFT

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_re  in  R_W(7)  input real part, r_t (Q1.6, signed)
in_im  in  R_W(7)  input imaginary part, r_t
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the sample
out_re  out  R_W(7)  output real part, r_t
out_im  out  R_W(7)  output imaginary part, r_t
out_sof  out  1  high on the first CP sample of each symbol
out_cp  out  1  high while the output sample belongs to the CP
theta_i  in  8  theta_t leading-offset length (used only with FRAME_OFFSET_EN; otherwise ignored)

Behaviour:
- Storage: ping-pong, 2 banks x N_FFT entries x 14 bits (re,im). Samples pass through unchanged: no rounding, no width change.
- Write side:
  - Input transfer = in_valid & in_ready. Sample goes to wr_bank[wr_idx]; wr_idx increments.
  - At wr_idx = N_FFT-1 the bank is marked full, wr_idx wraps to 0 and wr_bank toggles.
  - in_ready = !full[wr_bank].
- Read-side FSM:
  - IDLE: wait for full[rd_bank].
  - CP: emit indices N_FFT-N_CP .. N_FFT-1 with out_cp=1. out_sof=1 on the first of these only.
  - BODY: emit indices 0 .. N_FFT-1 with out_cp=0.
  - After BODY index N_FFT-1 is accepted: clear full[rd_bank] and toggle rd_bank. Go to CP if the other bank is full, else IDLE. There are no idle cycles between back-to-back symbols.
- Output register:
  - out_* are registered.
  - Load a new sample when (!out_valid | out_ready) and the FSM has data.
  - When out_valid & !out_ready, all out_* hold stable.
- Latency: first CP sample is valid 1 cycle after the cycle in which the N_FFT-th input sample is accepted.
- Throughput: N_FFT+N_CP output cycles per N_FFT input samples. The input stalls (in_ready=0) when both banks are full.
- Simultaneous events: a bank-full set (write side) and a bank-full clear (read side) on different banks in the same cycle are both honoured. The same bank is never written while it is being read.
- Reset values:
  - in_ready=1, out_valid=0, out_re=out_im=0, out_sof=0, out_cp=0.
  - Both banks empty; wr_idx=0, wr_bank=rd_bank=0; FSM=IDLE.
  - Memory contents are not reset.
- Reset mid-operation: any partial symbol on either side is discarded. The output stream restarts with out_sof on the next full symbol.

Optional Feature:
FRAME_OFFSET_EN:
- Defined:
  - The FSM adds an OFFSET state, entered once after reset, before the first CP.
  - In OFFSET it emits theta_i zero samples (out_cp=0, out_sof=0, out_valid=1). theta_i is sampled in the cycle rst falls.
  - theta_i=0 skips the state.
  - The purpose is to give the estimator a known timing offset theta.
- Undefined: no OFFSET state, and theta_i is unused.

Decomposition:
- Package data_type gains two localparams, N_FFT_DEF=256 and N_CP_DEF=16.
- The module uses the package's existing R_W and r_t for sample width, and theta_t for theta_i.
- Sub-module cp_buf_bank: one N_FFT x 14 register-array bank with synchronous write and combinational read; the block instantiates it twice.

Test Plan:
- Single symbol, in_re=index[6:0]-64, in_im=-in_re, out_ready=1 -> out_valid 1 cycle after the 256th input; 272 outputs.
  - Outputs 0..15 equal inputs 240..255 with out_cp=1; out_sof=1 only on output 0.
  - Outputs 16..271 equal inputs 0..255.
- Three back-to-back symbols with in_valid held 1 -> in_ready drops when both banks are full. Output is a continuous 816-sample stream with out_sof at samples 0, 272 and 544. No sample is lost or duplicated.
- Random out_ready (50%) -> out_* stay stable while out_valid & !out_ready; the stream content matches the fully-ready run.
- Assert rst for 1 cycle after 100 inputs, then send a full symbol -> the partial symbol is discarded. The first out_sof carries input sample 240 of the new symbol; all outputs are 0/valid=0 during reset.
- Extreme values: in_re=-64, in_im=63 -> the same codes appear at the output (no saturation or sign change).
- FRAME_OFFSET_EN defined, theta_i=37 -> 37 zero samples precede the first out_sof. With theta_i=0 the first output is the out_sof sample.

Source files
------------

// File: rtl/data_type.sv
// Shared sample/offset types and default OFDM sizes for the CP inserter.
// FRAME_OFFSET_EN adds the leading-offset FSM state.
package data_type;
    localparam int R_W = 7;
    localparam int N_FFT_DEF = 256;
    localparam int N_CP_DEF = 16;

    typedef logic signed [R_W-1:0] r_t;
    typedef logic [7:0] theta_t;

    typedef struct packed {
        r_t re;
        r_t im;
    } cplx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CP,
        S_BODY
`ifdef FRAME_OFFSET_EN
        ,S_OFFSET
`endif
    } cp_state_t;
endpackage

// File: rtl/ofdm_cp_inserter_bank.sv
// One symbol bank: register array, synchronous write, combinational read.
module cp_buf_bank #(
    parameter int DEPTH = 256,
    parameter int W = 14,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter: ping-pong symbol buffer, CP then body per symbol.
// Optional FRAME_OFFSET_EN: theta_i zero samples once after reset.
module ofdm_cp_inserter
    import data_type::*;
#(
    parameter int N_FFT = N_FFT_DEF,
    parameter int N_CP = N_CP_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [R_W-1:0]            in_re,
    input  logic [R_W-1:0]            in_im,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [R_W-1:0]            out_re,
    output logic [R_W-1:0]            out_im,
    output logic                      out_sof,
    output logic                      out_cp,
    input  logic [$bits(theta_t)-1:0] theta_i
);
    localparam int AW = $clog2(N_FFT);
    localparam int DW = 2 * R_W;
    localparam logic [AW-1:0] LAST = AW'(N_FFT - 1);
    localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);

    logic [AW-1:0] wr_idx, rd_idx, rd_idx_nx, eff_idx;
    logic          wr_bank, rd_bank, rd_bank_nx;
    logic          wr_fire, wr_last, has_data, load;
    logic          emit_cp, emit_sof, emit_zero;
    logic [1:0]    full, set_full, clr_full, avail, we;
    logic [DW-1:0] wdata, rdata0, rdata1, rd_word;
    cp_state_t     state, state_nx, eff_state;

`ifdef FRAME_OFFSET_EN
    logic [$bits(theta_t)-1:0] off_cnt;
`else
    logic unused_theta;
    assign unused_theta = ^theta_i;
`endif

    assign in_ready = !full[wr_bank];
    assign wr_fire = in_valid & in_ready;
    assign wr_last = wr_fire & (wr_idx == LAST);
    assign set_full = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign avail = full | set_full;
    assign wdata = {in_re, in_im};
    assign we[0] = wr_fire & !wr_bank;
    assign we[1] = wr_fire & wr_bank;

    cp_buf_bank #(.DEPTH(N_FFT), .W(DW), .AW(AW)) u_bank0 (
        .clk(clk), .we(we[0]), .waddr(wr_idx), .wdata(wdata),
        .raddr(eff_idx), .rdata(rdata0)
    );

    cp_buf_bank #(.DEPTH(N_FFT), .W(DW), .AW(AW)) u_bank1 (
        .clk(clk), .we(we[1]), .waddr(wr_idx), .wdata(wdata),
        .raddr(eff_idx), .rdata(rdata1)
    );

    // Forward the in-flight write so a symbol can start the cycle it completes.
    always_comb begin
        rd_word = rd_bank ? rdata1 : rdata0;
        if (wr_fire && wr_bank == rd_bank && wr_idx == eff_idx)
            rd_word = wdata;
    end

    always_comb begin
        eff_state = state;
        eff_idx = rd_idx;
        state_nx = state;
        rd_idx_nx = rd_idx;
        rd_bank_nx = rd_bank;
        clr_full = 2'b00;
        has_data = 1'b0;
        emit_cp = 1'b0;
        emit_sof = 1'b0;
        emit_zero = 1'b0;
        load = 1'b0;

        if (state == S_IDLE && avail[rd_bank]) begin
            eff_state = S_CP;
            eff_idx = CP_START;
        end

        case (eff_state)
            S_CP: begin
                has_data = 1'b1;
                emit_cp = 1'b1;
                emit_sof = (eff_idx == CP_START);
            end
            S_BODY: has_data = 1'b1;
`ifdef FRAME_OFFSET_EN
            S_OFFSET: begin
                has_data = 1'b1;
                emit_zero = 1'b1;
            end
`endif
            default: ;
        endcase

        load = has_data & (!out_valid | out_ready);

        if (load) begin
            case (eff_state)
                S_CP: begin
                    state_nx = (eff_idx == LAST) ? S_BODY : S_CP;
                    rd_idx_nx = eff_idx + 1'b1;
                end
                S_BODY: begin
                    if (eff_idx == LAST) begin
                        clr_full[rd_bank] = 1'b1;
                        rd_bank_nx = !rd_bank;
                        state_nx = avail[!rd_bank] ? S_CP : S_IDLE;
                        rd_idx_nx = CP_START;
                    end else begin
                        state_nx = S_BODY;
                        rd_idx_nx = eff_idx + 1'b1;
                    end
                end
`ifdef FRAME_OFFSET_EN
                S_OFFSET: begin
                    if (off_cnt == 1) state_nx = S_IDLE;
                end
`endif
                default: ;
            endcase
        end else begin
            state_nx = eff_state;
            rd_idx_nx = eff_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_idx <= CP_START;
            full <= 2'b00;
`ifdef FRAME_OFFSET_EN
            off_cnt <= theta_i;
            state <= (theta_i != 0) ? S_OFFSET : S_IDLE;
`else
            state <= S_IDLE;
`endif
        end else begin
            if (wr_fire) wr_idx <= wr_idx + 1'b1;
            if (wr_last) wr_bank <= !wr_bank;
            full <= (full & ~clr_full) | set_full;
            state <= state_nx;
            rd_idx <= rd_idx_nx;
            rd_bank <= rd_bank_nx;
`ifdef FRAME_OFFSET_EN
            if (load && eff_state == S_OFFSET) off_cnt <= off_cnt - 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re <= '0;
            out_im <= '0;
            out_sof <= 1'b0;
            out_cp <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_re <= emit_zero ? '0 : rd_word[DW-1:R_W];
            out_im <= emit_zero ? '0 : rd_word[R_W-1:0];
            out_sof <= emit_sof;
            out_cp <= emit_cp;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Directed bench for ofdm_cp_inserter with an output scoreboard queue.
module tb_ofdm_cp_inserter;
    localparam int NF = 256;
    localparam int NC = 16;

    logic clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [6:0] in_re, in_im, out_re, out_im;
    logic out_sof, out_cp;
    logic [7:0] theta_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit arm = 0;
    bit rand_mode = 0;
    bit stall_seen = 0;
    bit held = 0;
    logic [16:0] held_word;
    logic [15:0] q [$];

    ofdm_cp_inserter #(.N_FFT(NF), .N_CP(NC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_sof(out_sof), .out_cp(out_cp),
        .theta_i(theta_i)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] w;
        cyc++;
        if (!rst) begin
            if (held)
                check("hold", {out_re, out_im, out_cp, out_sof, out_valid},
                      held_word);
            if (in_valid && !in_ready) stall_seen = 1;
            if (out_valid && out_ready) begin
                check("q_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    w = q.pop_front();
                    check("stream", {out_re, out_im, out_cp, out_sof}, w);
                end
                last_cyc = cyc;
                if (arm) begin
                    first_cyc = cyc;
                    arm = 0;
                end
            end
            held = out_valid && !out_ready;
            held_word = {out_re, out_im, out_cp, out_sof, out_valid};
        end else begin
            held = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_sample(input logic [6:0] re, input logic [6:0] im);
        bit ok;
        int n;
        in_valid = 1;
        in_re = re;
        in_im = im;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 2000);
        if (!ok) check("in_timeout", 32'(ok), 1);
    endtask

    task automatic send_symbol(input int kind, input bit chk_lat);
        logic [13:0] sym [NF];
        logic [6:0] re, im;
        for (int i = 0; i < NF; i++) begin
            case (kind)
                0: begin
                    re = 7'(i) - 7'd64;
                    im = -re;
                end
                1: begin
                    re = 7'($urandom);
                    im = 7'($urandom);
                end
                default: begin
                    re = (i % 2 == 0) ? 7'h40 : 7'h3f;
                    im = (i % 2 == 0) ? 7'h3f : 7'h40;
                end
            endcase
            sym[i] = {re, im};
            push_sample(re, im);
        end
        for (int k = 0; k < NC; k++)
            q.push_back({sym[NF-NC+k], 1'b1, k == 0});
        for (int k = 0; k < NF; k++)
            q.push_back({sym[k], 2'b00});
        if (chk_lat) begin
            check("lat_valid", 32'(out_valid), 1);
            check("lat_sof", 32'(out_sof), 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        while ((q.size() != 0 || out_valid) && n < 4000) begin
            tick();
            n++;
        end
        check("drain", 32'(q.size()), 0);
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        in_re = 0;
        in_im = 0;
        out_ready = 1;
        theta_i = 8'd37;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", {out_re, out_im}, 0);
        check("rst_flags", {out_sof, out_cp}, 0);
        rst = 0;
`ifdef FRAME_OFFSET_EN
        for (int k = 0; k < 37; k++) q.push_back(16'h0000);
`endif

        send_symbol(0, 1);
        drain();

        stall_seen = 0;
        arm = 1;
        send_symbol(1, 0);
        send_symbol(0, 0);
        send_symbol(1, 0);
        drain();
        check("stall_seen", 32'(stall_seen), 1);
        check("b2b_span", last_cyc - first_cyc, 3 * (NF + NC) - 1);

        rand_mode = 1;
        send_symbol(0, 0);
        send_symbol(1, 0);
        drain();
        rand_mode = 0;
        tick();

        theta_i = 0;
        for (int i = 0; i < 100; i++) push_sample(7'(i), 7'(~i));
        in_valid = 0;
        rst = 1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", {out_re, out_im, out_sof, out_cp}, 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        rst = 0;
        send_symbol(0, 1);
        drain();

        send_symbol(2, 0);
        drain();

        repeat (5) tick();
        check("final_q", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
